// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and reset constants for the multi-channel PWM block.
//   pwm_mode_e     : alignment mode (PWM_EDGE = 0, PWM_CENTER = 1)
//   PWM_RST_PERIOD : reset value for period registers (all ones, sliced to W)
//   PWM_RST_DUTY   : reset value for duty registers (zero, sliced to W)
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // Widest supported counter; users slice [W-1:0].
  localparam int PWM_MAX_W = 16;

  localparam logic [PWM_MAX_W-1:0] PWM_RST_PERIOD = '1;
  localparam logic [PWM_MAX_W-1:0] PWM_RST_DUTY   = '0;

endpackage

// File: rtl/pwm_cmp_ch.sv
// pwm_cmp_ch: one PWM channel -- duty shadow register, active duty register,
// magnitude compare against the shared counter, and the output flop.
//   clk      in  clock
//   rst      in  synchronous active-high reset
//   en       in  run enable (output forced low when 0)
//   load     in  copy duty shadow into active duty this cycle
//   duty_wr  in  duty shadow write strobe
//   duty_sel in  channel index addressed by duty_wr
//   duty     in  duty value for the shadow
//   cnt      in  shared period counter
//   pwm_out  out registered channel output (high iff cnt < active duty)
module pwm_cmp_ch
  import pwm_pkg::*;
#(
  parameter int W   = 8,
  parameter int SW  = 2,
  parameter int IDX = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic          duty_wr,
  input  logic [SW-1:0] duty_sel,
  input  logic [W-1:0]  duty,
  input  logic [W-1:0]  cnt,
  output logic          pwm_out
);

  logic [W-1:0] duty_sh_q, duty_sh_d;
  logic [W-1:0] duty_q, duty_d;
  logic         out_q, out_d;
  logic         wr_hit;

  // Indices with no matching channel simply hit nothing.
  assign wr_hit = duty_wr && (duty_sel == SW'(IDX));

  always_comb begin
    duty_sh_d = duty_sh_q;
    duty_d    = duty_q;
    out_d     = 1'b0;
    if (wr_hit) duty_sh_d = duty;
    // Load takes the pre-write shadow, so a write in the boundary cycle
    // waits for the following boundary.
    if (load) duty_d = duty_sh_q;
    out_d = en && (cnt < duty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh_q <= PWM_RST_DUTY[W-1:0];
      duty_q    <= PWM_RST_DUTY[W-1:0];
      out_q     <= 1'b0;
    end else begin
      duty_sh_q <= duty_sh_d;
      duty_q    <= duty_d;
      out_q     <= out_d;
    end
  end

  assign pwm_out = out_q;

endmodule

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: CH-channel PWM generator sharing one period counter.
// Period, mode and duties are double-buffered (shadow -> active at a period
// boundary) so outputs never see a truncated or glitched period.
//   clk, rst     clock and synchronous active-high reset
//   en           run enable; low parks counter at 0, outputs low
//   period       period shadow value, captured on period_wr
//   period_wr    period/mode shadow write strobe
//   mode         alignment mode shadow (0 edge, 1 center), captured on period_wr
//   duty_wr      duty shadow write strobe
//   duty_sel     channel index for duty_wr (indices >= CH ignored)
//   duty         duty value for the selected channel shadow
//   pwm_out      registered PWM outputs, one per channel
//   period_tick  one-cycle pulse in the first output cycle of each period
// Build option: define PWM_CENTER_EN to compile in center-aligned (up/down)
// counting; otherwise the block is edge-aligned only and `mode` is unused.
//
// Write strobes: period_wr and duty_wr are single-cycle, always accepted
// (no backpressure); the written value reaches the active register at the
// next period boundary after the write cycle.
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int CH = 4,
  parameter int W  = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic [W-1:0]                        period,
  input  logic                                period_wr,
  input  logic                                mode,
  input  logic                                duty_wr,
  input  logic [$clog2(CH > 1 ? CH : 2)-1:0]  duty_sel,
  input  logic [W-1:0]                        duty,
  output logic [CH-1:0]                       pwm_out,
  output logic                                period_tick
);

  localparam int SW = $clog2(CH > 1 ? CH : 2);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] per_sh_q, per_sh_d;
  logic [W-1:0] per_q, per_d;
  logic         fresh_q, fresh_d;   // next cycle is the first of a period
  logic         tick_q, tick_d;
  logic         boundary;
  logic         load;

`ifdef PWM_CENTER_EN
  pwm_mode_e    mode_sh_q, mode_sh_d;
  pwm_mode_e    mode_q, mode_d;
  logic         dir_q, dir_d;       // 1 = counting down
`else
  logic         unused_mode;
  assign unused_mode = mode;
`endif

  // Last cycle of the current period.
  always_comb begin
    boundary = 1'b0;
    if (per_q == '0) begin
      boundary = 1'b1;
`ifdef PWM_CENTER_EN
    end else if (mode_q == PWM_CENTER) begin
      boundary = (cnt_q == '0) && dir_q;
`endif
    end else begin
      boundary = (cnt_q == per_q);
    end
  end

  // While parked, actives track shadows so the first enabled period is fresh.
  assign load = !en || boundary;

  always_comb begin
    per_sh_d = period_wr ? period : per_sh_q;
    per_d    = load ? per_sh_q : per_q;
    cnt_d    = cnt_q;
    fresh_d  = !en || boundary;
    tick_d   = en && fresh_q;
`ifdef PWM_CENTER_EN
    mode_sh_d = period_wr ? pwm_mode_e'(mode) : mode_sh_q;
    mode_d    = load ? mode_sh_q : mode_q;
    dir_d     = dir_q;
`endif
    if (!en || boundary) begin
      cnt_d = '0;
`ifdef PWM_CENTER_EN
      dir_d = 1'b0;
    end else if (mode_q == PWM_CENTER) begin
      // Turning points repeat: P-1 appears once going up, once going down.
      if (!dir_q) begin
        if (cnt_q == per_q - ONE) dir_d = 1'b1;
        else                      cnt_d = cnt_q + ONE;
      end else begin
        cnt_d = cnt_q - ONE;
      end
`endif
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      per_sh_q  <= PWM_RST_PERIOD[W-1:0];
      per_q     <= PWM_RST_PERIOD[W-1:0];
      fresh_q   <= 1'b1;
      tick_q    <= 1'b0;
`ifdef PWM_CENTER_EN
      mode_sh_q <= PWM_EDGE;
      mode_q    <= PWM_EDGE;
      dir_q     <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      per_sh_q  <= per_sh_d;
      per_q     <= per_d;
      fresh_q   <= fresh_d;
      tick_q    <= tick_d;
`ifdef PWM_CENTER_EN
      mode_sh_q <= mode_sh_d;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
`endif
    end
  end

  assign period_tick = tick_q;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_cmp_ch #(
      .W   (W),
      .SW  (SW),
      .IDX (i)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .load     (load),
      .duty_wr  (duty_wr),
      .duty_sel (duty_sel),
      .duty     (duty),
      .cnt      (cnt_q),
      .pwm_out  (pwm_out[i])
    );
  end

endmodule

// File: doc/pwm_multi_gen.md
# pwm_multi_gen

Multi-channel, parametrised PWM generator: a single shared period counter drives CH independent duty comparators with registered outputs. Duty, period and alignment mode are double-buffered: writes land in shadow registers and take effect only at a period boundary, so no output ever sees a glitched or truncated period. It sits between the user-input/register front end and the output pins, and supersedes the single-channel fixed-width PWM.

## Interface
- `CH`, 4, number of PWM channels (1..8)
- `W`, 8, counter/duty/period width in bits (2..16)
- `clk`  in  1  clock, all logic rising-edge
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  run enable; low = counter parked, outputs low
- `period`  in  W  shadow period value, captured when `period_wr`=1
- `period_wr`  in  1  period shadow write strobe
- `mode`  in  1  shadow alignment mode, 0 = edge, 1 = center; captured when `period_wr`=1
- `duty_wr`  in  1  duty shadow write strobe
- `duty_sel`  in  $clog2(CH) (min 1)  channel index for `duty_wr`; index ≥ CH ignored
- `duty`  in  W  duty value written to shadow[`duty_sel`]
- `pwm_out`  out  CH  registered PWM outputs
- `period_tick`  out  1  one-cycle pulse marking the first output cycle of each period

## Operation
- Reset: shadow/active period = all ones, mode = edge, all duties = 0, cnt = 0, dir = up; `pwm_out` = 0, `period_tick` = 0.
- Active registers (P, mode, d[i]) load from shadow only at a boundary. A write in the boundary cycle goes to the shadow; the load uses the pre-write shadow value, so the new value applies at the next boundary.
- Edge mode: cnt 0,1..P, wrap to 0; period = P+1 cycles. Boundary = cycle with cnt==P. Channel high iff cnt < d[i]: d=0 → always low, d ≥ P+1 → always high, else d high cycles.
- Center mode: cnt 0..P-1 up, then P-1..0 down (each end value repeated once); period = 2P cycles. Boundary = last down cycle (cnt==0, dir down). Channel high iff cnt < d[i]: 2·d high cycles centred on the valley; d ≥ P → always high.
- P = 0 (either mode): cnt held 0, every cycle is a boundary, `period_tick` constant 1, output = (d[i] != 0).
- `en`=0: cnt=0, dir=up, `pwm_out`=0, `period_tick`=0; active registers load from shadow every cycle; shadow writes accepted. First `en`=1 cycle starts a fresh period at cnt=0.
- Mode change at a boundary resets dir to up; cnt restarts at 0.

## Timing
- Compare is registered: `pwm_out` reflects cnt of the previous cycle (1-cycle latency from counter to pin).
- `period_tick` registered, high exactly in the cycle `pwm_out` first reflects cnt=0 of a new period (including first period after `en` rises: 1 cycle after `en`=1 sampled, ticks in cycle 2).
- Shadow write to visible output: earliest 2 cycles after the boundary following the write.
- `rst` dominates `en` and all strobes in the same cycle.

## Configuration
- `PWM_CENTER_EN` defined: center-aligned mode and up/down direction logic compiled in as above.
- Not defined: `mode` input and mode shadow ignored, block is edge-only; center logic absent. All other behaviour identical.

## Structure
- Package `pwm_pkg`: mode typedef (`PWM_EDGE`=0, `PWM_CENTER`=1), reset constants (period all ones, duty 0).
- Sub-module `pwm_cmp_ch`: per-channel duty shadow, active duty, compare and output flop; instantiated CH times by generate. Counter, direction, boundary and tick logic live in the top.

## Test plan
- Reset then `en`=1, W=8, edge, period=9, duty ch0=3 → ch0 pattern 3 high / 7 low, repeating every 10 cycles; tick every 10 cycles aligned with rising edge of ch0.
- Edge, period=9: duty 0 → ch constant 0; duty 10 and 255 → constant 1; no glitch at wrap.
- Write ch1 duty 2→6 mid-period, and again in the boundary cycle with 8 → current period keeps 2; next period 6; the period after 8.
- Center mode (macro on), period=5, duty=2 → 4 high / 6 low per 10-cycle period, high cycles centred on tick; with macro off same stimulus → edge behaviour, 2 high / 4 low per 6 cycles.
- Period=0, duties {0,1} → outputs {0,1} constant, tick constant 1.
- Drop `en` mid-period, then assert `rst` mid-period with `en`=1 → outputs 0 next cycle; after `rst` released, period all ones and all duties 0 (outputs stay low, tick every 256 cycles).
